// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: shares one single-port memory between two requesters.
// Port 0 is the command/RW flow controller, port 1 is the tx/sample path.
// Each granted request produces one memory strobe, waits out the read latency
// and returns a one-cycle ack together with the read data.
// Build option: define ARB_FIXED_PRIO_EN to give port 0 fixed priority on ties;
// the default build arbitrates ties round robin.
//
// Timing, with T the ACCESS cycle (mem_en high):
//   mem_rdata is captured on the edge that ends cycle T+MEM_LAT.
//   The ack pulses in cycle T+MEM_LAT+1, which is MEM_LAT+2 cycles after the
//   request was sampled in IDLE.
//   Back-to-back transactions are spaced MEM_LAT+3 cycles apart.
// To meet those numbers, WAIT always lasts MEM_LAT cycles, including when
// MEM_LAT is 1, and DONE is entered on the capture edge.

module mem_access_arbiter #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned MEM_LAT = 2   // legal range 1..15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              rw0,
  input  logic              rw1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_id
);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StWait,
    StDone
  } state_e;

  localparam logic [3:0] LatCnt = 4'(MEM_LAT);

  state_e     state_q;
  logic [3:0] cnt_q;
  logic       grant_win;

`ifndef ARB_FIXED_PRIO_EN
  logic       last_grant_q;
`endif

  // Pick the winner among the current requests; only used in IDLE.
  always_comb begin
    grant_win = 1'b0;
    if (req0 && req1) begin
`ifdef ARB_FIXED_PRIO_EN
      grant_win = 1'b0;
`else
      grant_win = ~last_grant_q;
`endif
    end else if (req1) begin
      grant_win = 1'b1;
    end
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      rdata0       <= '0;
      rdata1       <= '0;
      mem_en       <= 1'b0;
      mem_rw       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      busy         <= 1'b0;
      grant_id     <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      // Strobe and acks are single-cycle pulses.
      mem_en <= 1'b0;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req0 || req1) begin
            state_q   <= StAccess;
            busy      <= 1'b1;
            mem_en    <= 1'b1;
            grant_id  <= grant_win;
            // Memory pins double as the latched request; they hold until the next grant.
            mem_rw    <= grant_win ? rw1    : rw0;
            mem_addr  <= grant_win ? addr1  : addr0;
            mem_wdata <= grant_win ? wdata1 : wdata0;
          end
        end
        StAccess: begin
          cnt_q   <= LatCnt;
          state_q <= StWait;
        end
        StWait: begin
          if (cnt_q == 4'd1) begin
            state_q <= StDone;
            if (grant_id) begin
              ack1 <= 1'b1;
            end else begin
              ack0 <= 1'b1;
            end
            // This edge ends cycle T+MEM_LAT: read data is valid now.
            if (!mem_rw) begin
              if (grant_id) begin
                rdata1 <= mem_rdata;
              end else begin
                rdata0 <= mem_rdata;
              end
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StDone: begin
          state_q      <= StIdle;
          busy         <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
          last_grant_q <= grant_id;
`endif
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter: one instance with MEM_LAT=2 and one
// with MEM_LAT=1, each backed by a small behavioural memory with exact latency.

module tb_mem_access_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: MEM_LAT = 2
  logic       reset;
  logic       req0, req1, rw0, rw1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       ack0, ack1;
  logic [7:0] rdata0, rdata1;
  logic       mem_en, mem_rw;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       busy, grant_id;

  // Instance B: MEM_LAT = 1
  logic       reset_b;
  logic       req0_b, req1_b, rw0_b, rw1_b;
  logic [7:0] addr0_b, addr1_b, wdata0_b, wdata1_b;
  logic       ack0_b, ack1_b;
  logic [7:0] rdata0_b, rdata1_b;
  logic       mem_en_b, mem_rw_b;
  logic [7:0] mem_addr_b, mem_wdata_b, mem_rdata_b;
  logic       busy_b, grant_id_b;

  mem_access_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(2)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
  );

  mem_access_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(1)) dut_b (
    .clk(clk), .reset(reset_b),
    .req0(req0_b), .req1(req1_b), .rw0(rw0_b), .rw1(rw1_b),
    .addr0(addr0_b), .addr1(addr1_b), .wdata0(wdata0_b), .wdata1(wdata1_b),
    .ack0(ack0_b), .ack1(ack1_b), .rdata0(rdata0_b), .rdata1(rdata1_b),
    .mem_en(mem_en_b), .mem_rw(mem_rw_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_b), .busy(busy_b), .grant_id(grant_id_b)
  );

  // Memory model: fixed contents plus a write overlay from instance A.
  logic         model_clr;
  logic [255:0] wvld;
  logic [7:0]   wmem [256];
  logic [7:0]   pipe_a0, pipe_a1, pipe_b0;
  logic         vld_a0, vld_a1, vld_b0;

  function automatic logic [7:0] mem_rd(input logic [7:0] a);
    if (wvld[a]) return wmem[a];
    case (a)
      8'h10:   return 8'hA5;
      8'h20:   return 8'h77;
      default: return a ^ 8'h5A;
    endcase
  endfunction

  always @(posedge clk) begin
    if (model_clr) wvld <= '0;
    else if (mem_en && mem_rw) begin
      wvld[mem_addr] <= 1'b1;
      wmem[mem_addr] <= mem_wdata;
    end
    pipe_a0 <= mem_rd(mem_addr);
    vld_a0  <= mem_en && !mem_rw;
    pipe_a1 <= pipe_a0;
    vld_a1  <= vld_a0;
    pipe_b0 <= mem_rd(mem_addr_b);
    vld_b0  <= mem_en_b && !mem_rw_b;
  end

  // Data is only valid in the cycle the DUT is supposed to capture it.
  assign mem_rdata   = vld_a1 ? pipe_a1 : 8'hEE;
  assign mem_rdata_b = vld_b0 ? pipe_b0 : 8'hEE;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction on instance A, started from IDLE; returns in IDLE.
  task automatic run_a(input logic port, input logic rw, input logic [7:0] addr,
                       input logic [7:0] wdata, output int n, output int en_cnt,
                       output int en_at, output logic [7:0] en_addr,
                       output logic [7:0] en_wdata, output logic en_rw,
                       output int other_ack);
    n = 0; en_cnt = 0; en_at = 0; en_addr = '0; en_wdata = '0; en_rw = 1'b0;
    other_ack = 0;
    if (port) begin req1 = 1'b1; rw1 = rw; addr1 = addr; wdata1 = wdata; end
    else      begin req0 = 1'b1; rw0 = rw; addr0 = addr; wdata0 = wdata; end
    do begin
      step();
      n++;
      if (mem_en) begin
        en_cnt++; en_at = n; en_addr = mem_addr; en_wdata = mem_wdata; en_rw = mem_rw;
      end
      if (port ? ack0 : ack1) other_ack++;
    end while (!(port ? ack1 : ack0) && n < 20);
    req0 = 1'b0;
    req1 = 1'b0;
    step();
  endtask

  task automatic run_b(input logic port, input logic [7:0] addr, output int n,
                       output int en_cnt);
    n = 0; en_cnt = 0;
    if (port) begin req1_b = 1'b1; rw1_b = 1'b0; addr1_b = addr; end
    else      begin req0_b = 1'b1; rw0_b = 1'b0; addr0_b = addr; end
    do begin
      step();
      n++;
      if (mem_en_b) en_cnt++;
    end while (!(port ? ack1_b : ack0_b) && n < 20);
    req0_b = 1'b0;
    req1_b = 1'b0;
    step();
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [37:0] outs;
    model_clr = 1'b1;
    reset = 1'b0; reset_b = 1'b0;
    req0 = 0; req1 = 0; rw0 = 0; rw1 = 0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    req0_b = 0; req1_b = 0; rw0_b = 0; rw1_b = 0;
    addr0_b = 0; addr1_b = 0; wdata0_b = 0; wdata1_b = 0;
    step();
    step();
    model_clr = 1'b0;
    outs = {ack0, ack1, rdata0, rdata1, mem_en, mem_rw, mem_addr, mem_wdata, busy, grant_id};
    checks++;
    if (outs !== 38'd0) begin
      errors++; $display("FAIL reset_outputs_a: got %h expected 0", outs);
    end
    outs = {ack0_b, ack1_b, rdata0_b, rdata1_b, mem_en_b, mem_rw_b, mem_addr_b, mem_wdata_b,
            busy_b, grant_id_b};
    checks++;
    if (outs !== 38'd0) begin
      errors++; $display("FAIL reset_outputs_b: got %h expected 0", outs);
    end
    reset = 1'b1; reset_b = 1'b1;
    step();
  endtask

  task automatic test_read();
    int n, en_cnt, en_at, oth; logic [7:0] ea, ew; logic er;
    run_a(1'b0, 1'b0, 8'h10, 8'h00, n, en_cnt, en_at, ea, ew, er, oth);
    checks++; if (n !== 4) begin errors++; $display("FAIL read_latency: got %0d expected 4", n); end
    checks++; if (en_cnt !== 1) begin errors++; $display("FAIL read_en_count: got %0d expected 1", en_cnt); end
    checks++; if (en_at !== 1) begin errors++; $display("FAIL read_en_cycle: got %0d expected 1", en_at); end
    checks++; if (ea !== 8'h10 || er !== 1'b0) begin
      errors++; $display("FAIL read_mem_addr_rw: got %h/%b expected 10/0", ea, er);
    end
    checks++; if (oth !== 0) begin errors++; $display("FAIL read_ack1_quiet: got %0d expected 0", oth); end
    checks++; if (rdata0 !== 8'hA5) begin errors++; $display("FAIL read_rdata0: got %h expected a5", rdata0); end
  endtask

  task automatic test_write();
    int n, en_cnt, en_at, oth; logic [7:0] ea, ew; logic er;
    run_a(1'b1, 1'b0, 8'h20, 8'h00, n, en_cnt, en_at, ea, ew, er, oth);
    checks++; if (rdata1 !== 8'h77) begin errors++; $display("FAIL p1_read_rdata1: got %h expected 77", rdata1); end
    run_a(1'b1, 1'b1, 8'h3F, 8'h5C, n, en_cnt, en_at, ea, ew, er, oth);
    checks++; if (n !== 4) begin errors++; $display("FAIL write_latency: got %0d expected 4", n); end
    checks++; if (en_cnt !== 1) begin errors++; $display("FAIL write_en_count: got %0d expected 1", en_cnt); end
    checks++; if ({er, ea, ew} !== {1'b1, 8'h3F, 8'h5C}) begin
      errors++; $display("FAIL write_mem_pins: got %b/%h/%h expected 1/3f/5c", er, ea, ew);
    end
    checks++; if (rdata1 !== 8'h77) begin errors++; $display("FAIL write_rdata1_hold: got %h expected 77", rdata1); end
    run_a(1'b0, 1'b0, 8'h3F, 8'h00, n, en_cnt, en_at, ea, ew, er, oth);
    checks++; if (rdata0 !== 8'h5C) begin errors++; $display("FAIL write_readback: got %h expected 5c", rdata0); end
  endtask

  task automatic test_round_robin();
    logic exp_order [4];
    logic order [4];
    int   at [4];
    int   k = 0, both = 0, overlap = 0;
`ifdef ARB_FIXED_PRIO_EN
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    for (int i = 0; i < 4; i++) begin order[i] = 1'bx; at[i] = 0; end
    apply_reset();
    req0 = 1'b1; rw0 = 1'b0; addr0 = 8'h10;
    req1 = 1'b1; rw1 = 1'b0; addr1 = 8'h20;
    for (int n = 1; n <= 40 && k < 4; n++) begin
      step();
      if (ack0 && ack1) both++;
      if ((ack0 || ack1) && mem_en) overlap++;
      if (ack0 || ack1) begin
        order[k] = ack1; at[k] = n; k++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
    checks++; if (k !== 4) begin errors++; $display("FAIL rr_ack_count: got %0d expected 4", k); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (order[i] !== exp_order[i]) begin
        errors++; $display("FAIL rr_order[%0d]: got %b expected %b", i, order[i], exp_order[i]);
      end
    end
    checks++; if (at[0] !== 4) begin errors++; $display("FAIL rr_first_ack: got %0d expected 4", at[0]); end
    checks++; if (at[1] - at[0] !== 5) begin
      errors++; $display("FAIL rr_spacing: got %0d expected 5", at[1] - at[0]);
    end
    checks++; if (both !== 0 || overlap !== 0) begin
      errors++; $display("FAIL rr_exclusive: got %0d/%0d expected 0/0", both, overlap);
    end
  endtask

  task automatic test_busy_wait();
    req0 = 1'b1; rw0 = 1'b0; addr0 = 8'h10;
    for (int n = 1; n <= 9; n++) begin
      step();
      case (n)
        1: begin
          checks++; if (!(mem_en === 1'b1 && grant_id === 1'b0)) begin
            errors++; $display("FAIL busy_first_grant: got en=%b id=%b expected 1/0", mem_en, grant_id);
          end
        end
        2: begin req1 = 1'b1; rw1 = 1'b0; addr1 = 8'h55; end
        3: begin
          checks++; if (mem_en !== 1'b0 || grant_id !== 1'b0) begin
            errors++; $display("FAIL busy_no_preempt: got en=%b id=%b expected 0/0", mem_en, grant_id);
          end
        end
        4: begin
          checks++; if (ack0 !== 1'b1 || ack1 !== 1'b0) begin
            errors++; $display("FAIL busy_ack0: got %b%b expected 10", ack0, ack1);
          end
          req0 = 1'b0; addr1 = 8'h20;
        end
        5: begin
          checks++; if (busy !== 1'b0 || mem_en !== 1'b0) begin
            errors++; $display("FAIL busy_idle_gap: got busy=%b en=%b expected 0/0", busy, mem_en);
          end
        end
        6: begin
          checks++; if ({mem_en, grant_id, mem_addr} !== {1'b1, 1'b1, 8'h20}) begin
            errors++; $display("FAIL busy_late_sample: got %b/%b/%h expected 1/1/20",
                               mem_en, grant_id, mem_addr);
          end
        end
        9: begin
          checks++; if (ack1 !== 1'b1 || rdata1 !== 8'h77) begin
            errors++; $display("FAIL busy_ack1: got %b/%h expected 1/77", ack1, rdata1);
          end
          req1 = 1'b0;
        end
        default: ;
      endcase
    end
    step();
  endtask

  task automatic test_reset_mid();
    logic [37:0] outs;
    int acks = 0;
    int n, en_cnt, en_at, oth; logic [7:0] ea, ew; logic er;
    req0 = 1'b1; rw0 = 1'b0; addr0 = 8'h10;
    step();
    step();
    reset = 1'b0;
    #1;
    outs = {ack0, ack1, rdata0, rdata1, mem_en, mem_rw, mem_addr, mem_wdata, busy, grant_id};
    checks++;
    if (outs !== 38'd0) begin
      errors++; $display("FAIL midreset_outputs: got %h expected 0", outs);
    end
    req0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (ack0 || ack1) acks++;
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (ack0 || ack1) acks++;
    end
    checks++; if (acks !== 0) begin errors++; $display("FAIL midreset_no_ack: got %0d expected 0", acks); end
    run_a(1'b0, 1'b0, 8'h20, 8'h00, n, en_cnt, en_at, ea, ew, er, oth);
    checks++; if (n !== 4 || rdata0 !== 8'h77) begin
      errors++; $display("FAIL midreset_recover: got %0d/%h expected 4/77", n, rdata0);
    end
  endtask

  task automatic test_lat1();
    int n, en_cnt;
    run_b(1'b0, 8'h10, n, en_cnt);
    checks++; if (n !== 3) begin errors++; $display("FAIL lat1_latency: got %0d expected 3", n); end
    checks++; if (en_cnt !== 1) begin errors++; $display("FAIL lat1_en_count: got %0d expected 1", en_cnt); end
    checks++; if (rdata0_b !== 8'hA5) begin errors++; $display("FAIL lat1_rdata0: got %h expected a5", rdata0_b); end
    run_b(1'b1, 8'h20, n, en_cnt);
    checks++; if (n !== 3 || rdata1_b !== 8'h77) begin
      errors++; $display("FAIL lat1_port1: got %0d/%h expected 3/77", n, rdata1_b);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_round_robin();
    test_busy_wait();
    test_reset_mid();
    test_lat1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
